// File: rtl/mem_pkg.sv
// Shared definitions for the unified instruction/data memory controller.
package mem_pkg;

   // Access sizes carried on req_size.
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   // Controller states: accept, count down the latency, respond.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Request fields captured on accept (the address is kept separately
   // because its width is a parameter of the controller).
   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
   } req_t;

   // Halves must sit on even bytes, words on multiples of four.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      return ((size == SIZE_H) && lane[0]) || ((size == SIZE_W) && (lane != 2'b00));
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 32-bit memory word and the core's
// byte/half/word view: extract plus extension for loads, lane enables
// plus replicated data for stores.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh
);

   logic [31:0] byte_sh;
   logic [31:0] half_sh;

   // Little-endian: lane 0 is bits [7:0]; halves use the upper lane bit only.
   assign byte_sh = word >> {lane, 3'b000};
   assign half_sh = word >> {lane[1], 4'b0000};

   // Load path: pick the addressed bytes, then zero- or sign-extend.
   always_comb begin
      rdata = word;
      case (size)
         SIZE_B:  rdata = uns ? {24'h0, byte_sh[7:0]}
                              : {{24{byte_sh[7]}}, byte_sh[7:0]};
         SIZE_H:  rdata = uns ? {16'h0, half_sh[15:0]}
                              : {{16{half_sh[15]}}, half_sh[15:0]};
         default: rdata = word;
      endcase
   end

   // Store path: replicate the low bytes across the word so every lane
   // already holds the right data; the enables select which lanes land.
   always_comb begin
      be       = 4'b0000;
      wdata_sh = wdata;
      case (size)
         SIZE_B: begin
            be       = 4'b0001 << lane;
            wdata_sh = {4{wdata[7:0]}};
         end
         SIZE_H: begin
            be       = lane[1] ? 4'b1100 : 4'b0011;
            wdata_sh = {2{wdata[15:0]}};
         end
         SIZE_W: begin
            be       = 4'b1111;
            wdata_sh = wdata;
         end
         default: begin
            be       = 4'b0000;
            wdata_sh = wdata;
         end
      endcase
   end

endmodule

// File: rtl/main_mem_ctrl.sv
// Unified instruction/data memory for the multi-cycle RV32 core.
// One request in flight: accept in IDLE, wait LATENCY-1 cycles, and on the
// RESP edge commit any store and register the response, which is then
// presented for exactly one cycle.
module main_mem_ctrl
   import mem_pkg::*;
#(
   parameter int          ADDR_W     = 32,
   parameter int          DEPTH      = 256,
   parameter int          LATENCY    = 2,
   parameter logic [31:0] DATA_BASE  = 32'h000000C8,
   parameter int          WR_PROTECT = 1,
   parameter string       INIT_FILE  = "mem_init.hex"
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err
);

   localparam int            IW    = $clog2(DEPTH);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 4);
   localparam logic [ADDR_W:0] DBASE = (ADDR_W+1)'(DATA_BASE);

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   req_t              rq;
   logic [ADDR_W-1:0] rq_addr;
   logic              accept;
   logic              resp_fire;
   logic              wr_en;

   logic [1:0]        lane;
   logic [IW-1:0]     idx;
   logic              err;
   logic              out_of_range;
   logic              protect_hit;

   logic [31:0]       rd_word;
   logic [31:0]       ld_data;
   logic [3:0]        be;
   logic [31:0]       wdata_sh;

   reg   [31:0]       mem [0:DEPTH-1];

   assign accept = req_valid & req_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state: a latency of one skips the wait phase entirely.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
         S_WAIT:  if (cnt == 4'd1) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs; a store is dropped if reset lands on its commit edge.
   always_comb begin
      req_ready = (state == S_IDLE);
      resp_fire = (state == S_RESP);
      wr_en     = resp_fire & rq.we & ~err & rst_n;
   end

   // Capture the request on accept and count down the remaining latency.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= 4'd0;
      end else if (accept) begin
         rq.we    <= req_we;
         rq.size  <= req_size;
         rq.uns   <= req_unsigned;
         rq.wdata <= req_wdata;
         rq_addr  <= req_addr;
         cnt      <= 4'(LATENCY - 1);
      end else if ((state == S_WAIT) && (cnt != 4'd1)) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Error classification is done on the held request, not the live port.
   assign lane         = rq_addr[1:0];
   assign idx          = rq_addr[IW+1:2];
   assign out_of_range = ({1'b0, rq_addr} >= LIMIT);
   assign protect_hit  = rq.we && (WR_PROTECT != 0) && ({1'b0, rq_addr} < DBASE);
   assign err          = misaligned(rq.size, lane) || out_of_range ||
                         (rq.size == 2'd3) || protect_hit;

   assign rd_word = mem[idx];

   mem_lane_align u_align (
      .word     (rd_word),
      .lane     (lane),
      .size     (rq.size),
      .uns      (rq.uns),
      .wdata    (rq.wdata),
      .rdata    (ld_data),
      .be       (be),
      .wdata_sh (wdata_sh)
   );

   // Array write with per-byte enables; only the RESP edge can write.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en && be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
   end

   // Registered response: one-cycle valid, data zeroed on stores and errors.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= resp_fire;
         if (resp_fire) begin
            resp_err   <= err;
            resp_rdata <= (err || rq.we) ? 32'h0 : ld_data;
         end
      end
   end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Scoreboard bench for main_mem_ctrl at LATENCY 1, 2 and 4. The driver
// predicts each response from a byte-addressed reference memory and queues
// it; per-instance monitors pop and compare whenever resp_valid is seen.
module tb_main_mem_ctrl;

   localparam int NI    = 3;
   localparam int DEPTH = 256;
   localparam int DBASE = 32'hC8;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          mode;   // 0 data unknown, 1 must equal, 2 must differ
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n [NI];
   logic        rv    [NI];
   logic        rr    [NI];
   logic        resp_v[NI];
   logic [31:0] resp_d[NI];
   logic        resp_e[NI];
   logic        we, uns;
   logic [1:0]  size;
   logic [31:0] addr, wdata;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t expq [NI][$];
   logic [7:0] mb [NI][DEPTH*4];
   bit         kb [NI][DEPTH*4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat(input int k);
      return (k == 0) ? 1 : (k == 1) ? 2 : 4;
   endfunction

   generate
      for (genvar g = 0; g < NI; g++) begin : g_dut
         main_mem_ctrl #(
            .ADDR_W(32), .DEPTH(DEPTH), .LATENCY((g == 0) ? 1 : (g == 1) ? 2 : 4),
            .DATA_BASE(32'h000000C8), .WR_PROTECT(1), .INIT_FILE("")
         ) dut (
            .clk(clk), .rst_n(rst_n[g]), .req_valid(rv[g]), .req_ready(rr[g]),
            .req_we(we), .req_size(size), .req_unsigned(uns), .req_addr(addr),
            .req_wdata(wdata), .resp_valid(resp_v[g]), .resp_rdata(resp_d[g]),
            .resp_err(resp_e[g])
         );
         always @(negedge clk) mon(g);
      end
   endgenerate

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] ex);
      total++;
      if (act !== ex) begin
         bad++;
         $display("FAIL %s inst=%0d: got %h want %h", nm, k, act, ex);
      end
   endtask

   // Monitor: compare whatever the DUT presents against the oldest prediction.
   task automatic mon(input int k);
      exp_t e;
      if (resp_v[k] !== 1'b1) return;
      if (expq[k].size() == 0) begin
         total++; bad++;
         $display("FAIL unexpected_resp inst=%0d: got resp_valid=1 want none", k);
         return;
      end
      e = expq[k].pop_front();
      chk("resp_cycle", k, cyc, e.due);
      chk("resp_err", k, {31'h0, resp_e[k]}, {31'h0, e.err});
      if (e.mode == 1) chk("resp_rdata", k, resp_d[k], e.rdata);
      else if (e.mode == 2) begin
         total++;
         if (resp_d[k] === e.rdata) begin
            bad++;
            $display("FAIL protected_word inst=%0d: got %h want anything else", k, resp_d[k]);
         end
      end
   endtask

   task automatic wait_ready(input int k, output bit ok);
      int t = 0;
      while (rr[k] !== 1'b1 && t < 200) begin @(negedge clk); t++; end
      ok = (rr[k] === 1'b1);
      if (!ok) begin
         total++; bad++;
         $display("FAIL ready_timeout inst=%0d: got req_ready=0 want 1", k);
      end
   endtask

   // Issue one request at a negedge, predict it, and follow the busy window.
   // For loads, ne_chk marks wd as a value the response must not carry.
   task automatic issue(input int k, input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] wd, input bit ne_chk = 0);
      exp_t e; int n; int L; logic [31:0] v; bit known; bit ok;
      L = lat(k);
      n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
      e.err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) ||
              (a >= DEPTH*4) || (w && a < DBASE);
      e.rdata = 32'h0;
      e.mode  = 1;
      if (!e.err && w) begin
         for (int b = 0; b < n; b++) begin
            mb[k][a+b] = wd[8*b +: 8];
            kb[k][a+b] = 1'b1;
         end
      end
      if (!e.err && !w) begin
         v = 32'h0; known = 1'b1;
         for (int b = 0; b < n; b++) begin
            v[8*b +: 8] = mb[k][a+b];
            known = known & kb[k][a+b];
         end
         if (!u && n == 1) v = {{24{v[7]}}, v[7:0]};
         if (!u && n == 2) v = {{16{v[15]}}, v[15:0]};
         e.rdata = v;
         e.mode  = known ? 1 : 0;
         if (!known && ne_chk) begin e.rdata = wd; e.mode = 2; end
      end
      wait_ready(k, ok);
      if (!ok) return;
      we = w; size = sz; uns = u; addr = a; wdata = wd; rv[k] = 1'b1;
      @(posedge clk); #1;
      e.due = cyc + L;
      expq[k].push_back(e);
      rv[k] = 1'b0;
      for (int i = 0; i < L; i++) begin
         @(negedge clk);
         chk("ready_busy", k, {31'h0, rr[k]}, 32'h0);
      end
      @(negedge clk);
      chk("ready_back", k, {31'h0, rr[k]}, 32'h1);
   endtask

   // Start a store, then pull reset while it is still in flight.
   task automatic abort_store(input int k, input logic [31:0] a, input logic [31:0] wd);
      bit ok;
      wait_ready(k, ok);
      if (!ok) return;
      we = 1'b1; size = 2'd2; uns = 1'b0; addr = a; wdata = wd; rv[k] = 1'b1;
      @(posedge clk); #1;
      rv[k] = 1'b0;
      @(negedge clk);
      rst_n[k] = 1'b0;
      @(negedge clk);
      rst_n[k] = 1'b1;
      chk("ready_after_rst", k, {31'h0, rr[k]}, 32'h1);
      for (int i = 0; i < lat(k) + 2; i++) begin
         @(negedge clk);
         chk("no_resp_after_rst", k, {31'h0, resp_v[k]}, 32'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want test end");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NI; k++) begin
         rst_n[k] = 1'b0; rv[k] = 1'b0;
         for (int i = 0; i < DEPTH*4; i++) kb[k][i] = 1'b0;
      end
      we = 0; size = 0; uns = 0; addr = 0; wdata = 0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk("rst_ready", k, {31'h0, rr[k]}, 32'h1);
         chk("rst_valid", k, {31'h0, resp_v[k]}, 32'h0);
         chk("rst_rdata", k, resp_d[k], 32'h0);
         chk("rst_err", k, {31'h0, resp_e[k]}, 32'h0);
         rst_n[k] = 1'b1;
      end
      @(negedge clk);

      for (int k = 0; k < NI; k++) begin
         issue(k, 1, 2, 0, 32'h100, 32'hDEADBEEF);
         issue(k, 0, 2, 0, 32'h100, 32'h0);
         issue(k, 1, 0, 0, 32'h103, 32'h00000080);
         issue(k, 0, 0, 0, 32'h103, 32'h0);
         issue(k, 0, 0, 1, 32'h103, 32'h0);
         issue(k, 0, 2, 0, 32'h100, 32'h0);
         issue(k, 1, 1, 0, 32'h101, 32'h00001234);
         issue(k, 0, 2, 0, 32'h100, 32'h0);
         issue(k, 1, 1, 0, 32'h102, 32'h00008001);
         issue(k, 0, 1, 0, 32'h102, 32'h0);
         issue(k, 0, 1, 1, 32'h102, 32'h0);
         issue(k, 1, 2, 0, 32'h010, 32'h12345678);
         issue(k, 0, 2, 0, 32'h010, 32'h12345678, 1);
         issue(k, 0, 2, 0, 32'h400, 32'h0);
         issue(k, 0, 3, 0, 32'h100, 32'h0);
         issue(k, 1, 2, 0, 32'h0FC, 32'h1);
         issue(k, 1, 2, 0, 32'h104, 32'h0BADF00D);
         abort_store(k, 32'h104, 32'hCAFEF00D);
         issue(k, 0, 2, 0, 32'h104, 32'h0);

         for (int r = 0; r < 40; r++) begin
            bit w; bit u; logic [1:0] sz; logic [31:0] a; int n;
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            n  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
            if ($urandom_range(0, 4) == 0) a = 32'($urandom_range(0, 1279));
            else begin
               a = 32'($urandom_range(256, 319));
               if (sz != 2'd3) a = a & ~32'(n - 1);
            end
            issue(k, w, sz, u, a, $urandom);
         end
      end

      repeat (8) @(negedge clk);
      for (int k = 0; k < NI; k++) chk("pending_resp", k, expq[k].size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
